// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter:
// register index sizing and RISC-V load funct3 codes.
package regfile_writeback_arbiter_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_RSV = 3'b111
  } load_f3_e;

endpackage

// File: rtl/load_result_fifo.sv
// Load-result FIFO of {rd, data} entries with a
// parallel rd-match lookup for hazard queries.
module load_result_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int BITS  = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic [BITS-1:0]  push_data,
  input  logic             pop,
  output logic [REG_W-1:0] head_rd,
  output logic [BITS-1:0]  head_data,
  output logic             full,
  output logic             empty,
  input  logic [REG_W-1:0] q_ra,
  input  logic [REG_W-1:0] q_rb,
  output logic             hit_a,
  output logic             hit_b
);

  localparam int PW = $clog2(DEPTH);

  logic [REG_W-1:0] rd_q   [DEPTH];
  logic [BITS-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = cnt == (PW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;

  assign head_rd   = rd_q[rp];
  assign head_data = data_q[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      vld_q <= '0;
    end else begin
      if (do_push) begin
        vld_q[wp] <= 1'b1;
        wp        <= wp + 1'b1;
      end
      if (do_pop) begin
        vld_q[rp] <= 1'b0;
        rp        <= rp + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // payload needs no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_q[wp]   <= push_rd;
      data_q[wp] <= push_data;
    end
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_a = hit_a | (vld_q[i] & (rd_q[i] == q_ra));
      hit_b = hit_b | (vld_q[i] & (rd_q[i] == q_rb));
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: merges ALU results and extended
// load responses onto the register file write port.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [BITS-1:0]  alu_data,
  output logic             alu_stall,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [REG_W-1:0] load_rd,
  input  logic [2:0]       load_funct3,
  input  logic [BITS-1:0]  load_data,
  input  logic [REG_W-1:0] q_ra,
  input  logic [REG_W-1:0] q_rb,
  output logic             q_hit_a,
  output logic             q_hit_b,
  output logic             We,
  output logic [REG_W-1:0] Rw,
  output logic [BITS-1:0]  din
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [BITS-1:0]  ext;
  logic [REG_W-1:0] head_rd;
  logic [BITS-1:0]  head_data;
  logic             full, empty;
  logic             push, force_pop;
  logic             alu_win, fifo_win;
  logic             fhit_a, fhit_b;
  logic [SW-1:0]    starve;

  always_comb begin
    ext = load_data;
    unique case (load_f3_e'(load_funct3))
      F3_LB:  ext = {{(BITS-8){load_data[7]}}, load_data[7:0]};
      F3_LH:  ext = {{(BITS-16){load_data[15]}}, load_data[15:0]};
      F3_LW:  ext = {{(BITS-32){load_data[31]}}, load_data[31:0]};
      F3_LBU: ext = {{(BITS-8){1'b0}}, load_data[7:0]};
      F3_LHU: ext = {{(BITS-16){1'b0}}, load_data[15:0]};
      F3_LWU: ext = {{(BITS-32){1'b0}}, load_data[31:0]};
      F3_LD,
      F3_RSV: ext = load_data;
    endcase
  end

  // rd=0 loads complete the handshake but are dropped
  assign load_ready = !full;
  assign push = load_valid & load_ready & (load_rd != '0);

  assign force_pop = (starve == SW'(STARVE_MAX)) & !empty;
  assign alu_stall = alu_valid & force_pop;
  assign alu_win   = alu_valid & !force_pop;
  assign fifo_win  = !empty & (force_pop | !alu_valid);

  load_result_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (load_rd),
    .push_data (ext),
    .pop       (fifo_win),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .q_ra      (q_ra),
    .q_rb      (q_rb),
    .hit_a     (fhit_a),
    .hit_b     (fhit_b)
  );

  assign q_hit_a = (q_ra != '0) &
                   ((We & (Rw == q_ra)) | fhit_a);
  assign q_hit_b = (q_rb != '0) &
                   ((We & (Rw == q_rb)) | fhit_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      We     <= 1'b0;
      Rw     <= '0;
      din    <= '0;
      starve <= '0;
    end else begin
      We <= 1'b0;
      if (alu_win) begin
        if (alu_rd != '0) begin
          We  <= 1'b1;
          Rw  <= alu_rd;
          din <= alu_data;
        end
      end else if (fifo_win) begin
        We  <= 1'b1;
        Rw  <= head_rd;
        din <= head_data;
      end
      if (empty || fifo_win)
        starve <= '0;
      else if (alu_win && starve != SW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end

endmodule
